// File: rtl/view_matrix_engine.sv
// Camera view-matrix generator: latches position/angles, builds rotation and
// translation matrices and multiplies them one element per cycle.

module trig_lookup (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [7:0]        angle,
    output logic signed [7:0] sin_val,
    output logic signed [7:0] cos_val
);

    // Quarter-wave table: round(127 * sin(idx * 90deg / 64)), idx = 0..64
    function automatic logic [6:0] quarter(input logic [6:0] idx);
        case (idx)
            7'd0:  quarter = 7'd0;   7'd1:  quarter = 7'd3;   7'd2:  quarter = 7'd6;
            7'd3:  quarter = 7'd9;   7'd4:  quarter = 7'd12;  7'd5:  quarter = 7'd16;
            7'd6:  quarter = 7'd19;  7'd7:  quarter = 7'd22;  7'd8:  quarter = 7'd25;
            7'd9:  quarter = 7'd28;  7'd10: quarter = 7'd31;  7'd11: quarter = 7'd34;
            7'd12: quarter = 7'd37;  7'd13: quarter = 7'd40;  7'd14: quarter = 7'd43;
            7'd15: quarter = 7'd46;  7'd16: quarter = 7'd49;  7'd17: quarter = 7'd51;
            7'd18: quarter = 7'd54;  7'd19: quarter = 7'd57;  7'd20: quarter = 7'd60;
            7'd21: quarter = 7'd63;  7'd22: quarter = 7'd65;  7'd23: quarter = 7'd68;
            7'd24: quarter = 7'd71;  7'd25: quarter = 7'd73;  7'd26: quarter = 7'd76;
            7'd27: quarter = 7'd78;  7'd28: quarter = 7'd81;  7'd29: quarter = 7'd83;
            7'd30: quarter = 7'd85;  7'd31: quarter = 7'd88;  7'd32: quarter = 7'd90;
            7'd33: quarter = 7'd92;  7'd34: quarter = 7'd94;  7'd35: quarter = 7'd96;
            7'd36: quarter = 7'd98;  7'd37: quarter = 7'd100; 7'd38: quarter = 7'd102;
            7'd39: quarter = 7'd104; 7'd40: quarter = 7'd106; 7'd41: quarter = 7'd107;
            7'd42: quarter = 7'd109; 7'd43: quarter = 7'd111; 7'd44: quarter = 7'd112;
            7'd45: quarter = 7'd113; 7'd46: quarter = 7'd115; 7'd47: quarter = 7'd116;
            7'd48: quarter = 7'd117; 7'd49: quarter = 7'd118; 7'd50: quarter = 7'd120;
            7'd51: quarter = 7'd121; 7'd52: quarter = 7'd122; 7'd53: quarter = 7'd122;
            7'd54: quarter = 7'd123; 7'd55: quarter = 7'd124; 7'd56: quarter = 7'd125;
            7'd57: quarter = 7'd125; 7'd58: quarter = 7'd126; 7'd59: quarter = 7'd126;
            7'd60: quarter = 7'd126; 7'd61: quarter = 7'd127; 7'd62: quarter = 7'd127;
            7'd63: quarter = 7'd127;
            default: quarter = 7'd127;
        endcase
    endfunction

    // Odd quadrants mirror the table index, the lower half-turn negates it
    function automatic logic signed [7:0] sine(input logic [7:0] a);
        logic [6:0] mag;
        mag = a[6] ? quarter(7'd64 - {1'b0, a[5:0]}) : quarter({1'b0, a[5:0]});
        sine = a[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sin_val <= '0;
            cos_val <= '0;
        end else begin
            sin_val <= sine(angle);
            cos_val <= sine(angle + 8'd64);
        end
    end

endmodule

module view_matrix_engine #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int ROLL_EN = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start,
    input  logic [WIDTH-1:0]            x_in,
    input  logic [WIDTH-1:0]            y_in,
    input  logic [WIDTH-1:0]            z_in,
    input  logic [7:0]                  yaw_in,
    input  logic [7:0]                  pitch_in,
    input  logic [7:0]                  roll_in,
    output logic                        busy,
    output logic                        done,
    output logic [3:0][3:0][WIDTH-1:0]  view_matrix,
    output logic [2:0][WIDTH-1:0]       forward_vec
);

    localparam int SW = 2 * WIDTH + 2;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [WIDTH-1:0] NEG_ONE = -ONE;
    localparam logic [1:0]       LAST_PASS = (ROLL_EN != 0) ? 2'd2 : 2'd1;

    typedef logic [3:0][3:0][WIDTH-1:0] mat_t;
    typedef enum logic [2:0] {IDLE, TRIG0, TRIG1, BUILD, MUL, FINISH} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] x_lat, y_lat, z_lat;
    logic [7:0]       yaw_lat, pitch_lat, roll_lat;
    logic signed [7:0] yaw_sin, yaw_cos, pitch_sin, pitch_cos, roll_sin, roll_cos;
    logic [WIDTH-1:0] sy, cy, sp, cp, sr, cr;

    mat_t rz, rx, ry, tm, right_mat, left_mat, scratch, scratch_next;
    logic [1:0]       pass;
    logic [3:0]       k;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [SW-1:0]      acc, shifted;
    logic [WIDTH-1:0]          elem;

    function automatic logic [WIDTH-1:0] to_fixed(input logic signed [7:0] v);
        if (v >= 8'sd127)
            to_fixed = ONE;
        else if (v <= -8'sd127)
            to_fixed = NEG_ONE;
        else
            to_fixed = {{(WIDTH-8){v[7]}}, v} << (FRAC - 7);
    endfunction

    trig_lookup u_yaw   (.clk_in(clk_in), .rst_in(rst_in), .angle(yaw_lat),
                         .sin_val(yaw_sin), .cos_val(yaw_cos));
    trig_lookup u_pitch (.clk_in(clk_in), .rst_in(rst_in), .angle(pitch_lat),
                         .sin_val(pitch_sin), .cos_val(pitch_cos));
    trig_lookup u_roll  (.clk_in(clk_in), .rst_in(rst_in), .angle(roll_lat),
                         .sin_val(roll_sin), .cos_val(roll_cos));

    // Roll drives Rz, pitch drives Rx, yaw drives Ry
    always_comb begin
        rz = '0;
        rz[0][0] = cr;  rz[0][1] = sr;  rz[1][0] = -sr; rz[1][1] = cr;
        rz[2][2] = ONE; rz[3][3] = ONE;
        rx = '0;
        rx[0][0] = ONE; rx[1][1] = cp;  rx[1][2] = sp;  rx[2][1] = -sp;
        rx[2][2] = cp;  rx[3][3] = ONE;
        ry = '0;
        ry[0][0] = cy;  ry[0][2] = sy;  ry[1][1] = ONE; ry[2][0] = -sy;
        ry[2][2] = cy;  ry[3][3] = ONE;
        tm = '0;
        tm[0][0] = ONE; tm[1][1] = ONE; tm[2][2] = ONE; tm[3][3] = ONE;
        tm[0][3] = x_lat; tm[1][3] = y_lat; tm[2][3] = z_lat;
    end

    always_comb begin
        right_mat = tm;
        if (ROLL_EN != 0) begin
            if (pass == 2'd0)
                right_mat = rx;
            else if (pass == 2'd1)
                right_mat = ry;
        end else if (pass == 2'd0) begin
            right_mat = ry;
        end
    end

    // Element k = row*4 + col: dot product, floor shift by FRAC, then saturate
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int j = 0; j < 4; j++) begin
            prod = $signed(left_mat[k[3:2]][j[1:0]]) * $signed(right_mat[j[1:0]][k[1:0]]);
            acc  = acc + {{2{prod[2*WIDTH-1]}}, prod};
        end
        shifted = acc >>> FRAC;
        if (shifted[SW-1:WIDTH-1] == '0 || shifted[SW-1:WIDTH-1] == '1)
            elem = shifted[WIDTH-1:0];
        else if (shifted[SW-1])
            elem = {1'b1, {(WIDTH-1){1'b0}}};
        else
            elem = {1'b0, {(WIDTH-1){1'b1}}};
        scratch_next = scratch;
        scratch_next[k[3:2]][k[1:0]] = elem;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = TRIG0;
            TRIG0:   state_next = TRIG1;
            TRIG1:   state_next = BUILD;
            BUILD:   state_next = MUL;
            MUL:     if (k == 4'd15 && pass == LAST_PASS) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The finished pass result becomes the next left operand in the same edge
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_lat <= '0; y_lat <= '0; z_lat <= '0;
            yaw_lat <= '0; pitch_lat <= '0; roll_lat <= '0;
            sy <= '0; cy <= '0; sp <= '0; cp <= '0; sr <= '0; cr <= '0;
            left_mat    <= '0;
            scratch     <= '0;
            pass        <= '0;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            view_matrix <= '0;
            forward_vec <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_lat     <= x_in;
                        y_lat     <= y_in;
                        z_lat     <= z_in;
                        yaw_lat   <= yaw_in;
                        pitch_lat <= pitch_in;
                        roll_lat  <= (ROLL_EN != 0) ? roll_in : 8'd0;
                        busy      <= 1'b1;
                    end
                end
                TRIG1: begin
                    sy <= to_fixed(yaw_sin);   cy <= to_fixed(yaw_cos);
                    sp <= to_fixed(pitch_sin); cp <= to_fixed(pitch_cos);
                    sr <= to_fixed(roll_sin);  cr <= to_fixed(roll_cos);
                end
                BUILD: begin
                    left_mat <= (ROLL_EN != 0) ? rz : rx;
                    pass     <= 2'd0;
                    k        <= 4'd0;
                end
                MUL: begin
                    scratch <= scratch_next;
                    k       <= k + 4'd1;
                    if (k == 4'd15) begin
                        left_mat <= scratch_next;
                        pass     <= pass + 2'd1;
                    end
                end
                FINISH: begin
                    view_matrix <= scratch;
                    forward_vec <= {scratch[2][2], scratch[2][1], scratch[2][0]};
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
